// File: rtl/display_arbiter.sv
// Arbitrates the shared seven-segment display between input prompt, program output and PC display,
// holding each grant for HOLD_CYCLES; define DISP_ARB_RR_EN for round-robin instead of fixed priority.
module display_arbiter #(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp_req,
    input  logic             out_req,
    input  logic [7:0]       out_data,
    input  logic             pc_req,
    input  logic [7:0]       pc_val,
    input  logic             cpu_busy,
    output logic             inp_gnt,
    output logic             out_gnt,
    output logic             pc_gnt,
    output logic [7:0]       disp_data,
    output logic             disp_inp,
    output logic             disp_pc,
    output logic             disp_busy,
    output logic [1:0]       disp_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INP  = 2'd1,
        ST_OUT  = 2'd2,
        ST_PC   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    state_t           winner;
    logic [CNT_W-1:0] dwell;
    logic             win_open;
    logic             any_req;

`ifdef DISP_ARB_RR_EN
    // Source at which the next search begins
    state_t rr_ptr;
`endif

    always_comb begin
        any_req  = inp_req | out_req | pc_req;
        win_open = (state == ST_IDLE) || (dwell == '0);
        winner   = ST_IDLE;
`ifdef DISP_ARB_RR_EN
        case (rr_ptr)
            ST_OUT: begin
                if (out_req)      winner = ST_OUT;
                else if (pc_req)  winner = ST_PC;
                else if (inp_req) winner = ST_INP;
            end
            ST_PC: begin
                if (pc_req)       winner = ST_PC;
                else if (inp_req) winner = ST_INP;
                else if (out_req) winner = ST_OUT;
            end
            default: begin
                if (inp_req)      winner = ST_INP;
                else if (out_req) winner = ST_OUT;
                else if (pc_req)  winner = ST_PC;
            end
        endcase
`else
        if (inp_req)      winner = ST_INP;
        else if (out_req) winner = ST_OUT;
        else if (pc_req)  winner = ST_PC;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            dwell     <= '0;
            inp_gnt   <= 1'b0;
            out_gnt   <= 1'b0;
            pc_gnt    <= 1'b0;
            disp_data <= 8'd0;
            disp_inp  <= 1'b0;
            disp_pc   <= 1'b0;
            disp_busy <= 1'b0;
`ifdef DISP_ARB_RR_EN
            rr_ptr    <= ST_INP;
`endif
        end else begin
            inp_gnt   <= 1'b0;
            out_gnt   <= 1'b0;
            pc_gnt    <= 1'b0;
            disp_busy <= cpu_busy;
            if (win_open && any_req) begin
                state <= winner;
                dwell <= DWELL_LOAD;
                case (winner)
                    ST_INP: begin
                        inp_gnt  <= 1'b1;
                        disp_inp <= 1'b1;
                        disp_pc  <= 1'b0;
                    end
                    ST_OUT: begin
                        out_gnt   <= 1'b1;
                        disp_data <= out_data;
                        disp_inp  <= 1'b0;
                        disp_pc   <= 1'b0;
                    end
                    ST_PC: begin
                        pc_gnt    <= 1'b1;
                        disp_data <= pc_val;
                        disp_inp  <= 1'b0;
                        disp_pc   <= 1'b1;
                    end
                    default: ;
                endcase
`ifdef DISP_ARB_RR_EN
                case (winner)
                    ST_INP:  rr_ptr <= ST_OUT;
                    ST_OUT:  rr_ptr <= ST_PC;
                    default: rr_ptr <= ST_INP;
                endcase
`endif
            end else if (dwell != '0) begin
                dwell <= dwell - 1'b1;
            end
        end
    end

    assign disp_state = state;

endmodule
